// File: rtl/adxl357_pkg.sv
// Shared constants and FSM state type for the ADXL357 averaging/decimation path.
package adxl357_pkg;
    localparam logic [2:0] OP_HW            = 3'd4;
    localparam int         ACC_W            = 20;
    localparam int         TEMP_W           = 12;
    localparam int         STATUS_SM_EN_BIT = 10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_ACCUM,
        S_EMIT
    } state_t;
endpackage

// File: rtl/adxl357_chan_acc.sv
// One channel: capture register, boxcar accumulator and shift-down to the average.
// ADXL357_AVG_ROUND_EN adds half an LSB of the result before the shift (round half up).
module adxl357_chan_acc
    import adxl357_pkg::*;
#(
    parameter int W        = ACC_W,
    parameter int LOG2_AVG = 2,
    parameter bit SIGNED   = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_sample,
    input  logic         i_cap,
    input  logic         i_add,
    input  logic         i_clr,
    output logic [W-1:0] o_avg
);
    localparam int AW = W + LOG2_AVG;

    logic [W-1:0]  cap_r;
    logic [AW-1:0] acc_r;
    logic [AW-1:0] ext;
    logic [AW-1:0] rnd;
    logic [AW-1:0] sum;

    generate
        if (LOG2_AVG == 0) begin : g_ext0
            assign ext = cap_r;
            assign rnd = '0;
        end else begin : g_extn
            assign ext = {{LOG2_AVG{SIGNED & cap_r[W-1]}}, cap_r};
`ifdef ADXL357_AVG_ROUND_EN
            assign rnd = AW'(1) << (LOG2_AVG - 1);
`else
            assign rnd = '0;
`endif
        end
    endgenerate

    // The rounding offset cannot overflow: the sum is at most 2^L*max + 2^(L-1).
    assign sum = acc_r + rnd;

    generate
        if (SIGNED) begin : g_sgn
            assign o_avg = W'($signed(sum) >>> LOG2_AVG);
        end else begin : g_uns
            assign o_avg = W'(sum >> LOG2_AVG);
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cap_r <= '0;
            acc_r <= '0;
        end else begin
            if (i_cap) begin
                cap_r <= i_sample;
            end
            if (i_clr) begin
                acc_r <= '0;
            end else if (i_add) begin
                acc_r <= acc_r + ext;
            end
        end
    end
endmodule

// File: rtl/adxl357_avg_decimator.sv
// Averages 2^LOG2_AVG hardware-mode burst reads into one decimated frame with overrun/stale flags.
// Optional ADXL357_AVG_ROUND_EN selects round-half-up instead of truncation.
//
// state     | meaning
// S_IDLE    | waiting for a burst-complete event (capture regs load on the way out)
// S_CAPTURE | capture regs hold the sample; it is added into the accumulators
// S_ACCUM   | sample counted; emit the frame if the window is complete
// S_EMIT    | frame just presented, accumulators restarted
module adxl357_avg_decimator
    import adxl357_pkg::*;
#(
    parameter int LOG2_AVG    = 2,
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_ctrl,
    input  logic [31:0] i_status,
    input  logic [31:0] i_accx,
    input  logic [31:0] i_accy,
    input  logic [31:0] i_accz,
    input  logic [31:0] i_temp,
    input  logic        i_clear,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_accx,
    output logic [31:0] o_accy,
    output logic [31:0] o_accz,
    output logic [31:0] o_temp,
    output logic        o_overrun,
    output logic        o_stale
);
    localparam int                TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]     TMO_MAX  = TW'(TIMEOUT_CYC);
    localparam logic [LOG2_AVG:0] CNT_FULL = (LOG2_AVG + 1)'(1) << LOG2_AVG;

    state_t              state_q, state_d;
    logic                r_en_d;
    logic [LOG2_AVG:0]   cnt_q;
    logic [TW-1:0]       tmo_q;
    logic                hw_mode, evt;
    logic                cap_en, add_en, emit, acc_clr;
    logic [ACC_W-1:0]    avg_x, avg_y, avg_z;
    logic [TEMP_W-1:0]   avg_t;
    logic [ACC_W-1:0]    q_x, q_y, q_z;
    logic [TEMP_W-1:0]   q_t;

    assign hw_mode = (i_ctrl[3:1] == OP_HW);
    assign evt     = r_en_d & ~i_status[STATUS_SM_EN_BIT] & hw_mode;

    always_comb begin
        state_d = state_q;
        cap_en  = 1'b0;
        add_en  = 1'b0;
        emit    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (evt) begin
                    cap_en  = 1'b1;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                add_en  = 1'b1;
                state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (cnt_q == CNT_FULL) begin
                    emit    = 1'b1;
                    state_d = S_EMIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EMIT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Leaving HW mode or a clear abandons the partial window.
        if (i_clear || !hw_mode) begin
            state_d = S_IDLE;
            cap_en  = 1'b0;
            add_en  = 1'b0;
            emit    = 1'b0;
        end
    end

    assign acc_clr = i_clear | ~hw_mode | emit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            r_en_d  <= 1'b0;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            r_en_d  <= i_status[STATUS_SM_EN_BIT];
            if (acc_clr) begin
                cnt_q <= '0;
            end else if (add_en) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (i_clear || evt) begin
                tmo_q <= '0;
            end else if (tmo_q != TMO_MAX) begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
            q_x       <= '0;
            q_y       <= '0;
            q_z       <= '0;
            q_t       <= '0;
        end else if (i_clear) begin
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
        end else if (emit) begin
            q_x     <= avg_x;
            q_y     <= avg_y;
            q_z     <= avg_z;
            q_t     <= avg_t;
            o_valid <= 1'b1;
            if (o_valid && !i_ready) begin
                o_overrun <= 1'b1;
            end
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

    assign o_accx  = {{(32 - ACC_W){q_x[ACC_W-1]}}, q_x};
    assign o_accy  = {{(32 - ACC_W){q_y[ACC_W-1]}}, q_y};
    assign o_accz  = {{(32 - ACC_W){q_z[ACC_W-1]}}, q_z};
    assign o_temp  = {{(32 - TEMP_W){1'b0}}, q_t};
    assign o_stale = (tmo_q == TMO_MAX);

    adxl357_chan_acc #(.W(ACC_W), .LOG2_AVG(LOG2_AVG), .SIGNED(1'b1)) u_acc_x (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sample(i_accx[ACC_W-1:0]),
        .i_cap(cap_en), .i_add(add_en), .i_clr(acc_clr), .o_avg(avg_x)
    );
    adxl357_chan_acc #(.W(ACC_W), .LOG2_AVG(LOG2_AVG), .SIGNED(1'b1)) u_acc_y (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sample(i_accy[ACC_W-1:0]),
        .i_cap(cap_en), .i_add(add_en), .i_clr(acc_clr), .o_avg(avg_y)
    );
    adxl357_chan_acc #(.W(ACC_W), .LOG2_AVG(LOG2_AVG), .SIGNED(1'b1)) u_acc_z (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sample(i_accz[ACC_W-1:0]),
        .i_cap(cap_en), .i_add(add_en), .i_clr(acc_clr), .o_avg(avg_z)
    );
    adxl357_chan_acc #(.W(TEMP_W), .LOG2_AVG(LOG2_AVG), .SIGNED(1'b0)) u_acc_t (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sample(i_temp[TEMP_W-1:0]),
        .i_cap(cap_en), .i_add(add_en), .i_clr(acc_clr), .o_avg(avg_t)
    );
endmodule
